wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults, requester indices and helpers for the write-back arbiter
package wb_pkg;

  localparam int WB_NREQ   = 3;
  localparam int WB_DATA_W = 19;
  localparam int WB_ADDR_W = 3;

  // Requester slots on req_valid/req_ready
  localparam int REQ_ALU = 0;
  localparam int REQ_FFT = 1;
  localparam int REQ_CRY = 2;

  // Round-robin distance of index i from the slot just after ptr (0 = highest priority)
  function automatic int rr_dist(input int i, input int ptr, input int n);
    return (i + n - ptr - 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NREQ-wide round-robin grant with a pointer to the last granted requester
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] grant_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               best_dist;
  int               best_idx;
  logic             found;

  // Pick the valid requester closest after the pointer; grants are masked while in reset
  always_comb begin
    best_dist = NREQ;
    best_idx  = 0;
    found     = 1'b0;
    grant_o   = '0;
    ptr_d     = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (valid_i[i] && (rr_dist(i, int'(ptr_q), NREQ) < best_dist)) begin
        best_dist = rr_dist(i, int'(ptr_q), NREQ);
        best_idx  = i;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = found && rst_n && (i == best_idx);
    end
    // A grant always completes (ready only goes high with valid), so it moves the pointer
    if (found && rst_n) begin
      ptr_d = IDX_W'(best_idx);
    end
  end

  // Pointer register; reset to the last slot so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter with registered register-file port; WB_SCOREBOARD_EN adds a busy scoreboard
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ   = WB_NREQ,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   reg_write,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  output logic                   stall,
  output logic [NREG-1:0]        busy
);

  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .grant_o (req_ready)
  );

  // One-hot mux of the granted requester's address and data
  always_comb begin
    xfer     = |req_ready;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register 0 transfers are swallowed; the write port keeps its last address/data when idle
  always_comb begin
    we_d      = xfer && (sel_addr != '0);
    rd_addr_d = we_d ? sel_addr : rd_addr_q;
    wb_data_d = we_d ? sel_data : wb_data_q;
  end

  // Output stage; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign reg_write = we_q;
  assign rd_addr   = rd_addr_q;
  assign wb_data   = wb_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;

  // Set wins over clear so a re-issue racing the old write keeps the register pending
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) begin
      set_mask[issue_addr] = 1'b1;
    end
    if (xfer) begin
      clr_mask[sel_addr] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // Scoreboard storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q[rs1_addr] | busy_q[rs2_addr];
`else
  logic unused_scoreboard_inputs;

  assign unused_scoreboard_inputs = ^{issue_valid, issue_addr, rs1_addr, rs2_addr};
  assign busy  = '0;
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and random scoreboard bench for wb_arbiter
module tb_wb_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   reg_write;
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_addr;
  logic [ADDR_W-1:0]      rs1_addr;
  logic [ADDR_W-1:0]      rs2_addr;
  logic                   stall;
  logic [NREG-1:0]        busy;

  int checks   = 0;
  int failures = 0;

  wr_t               exp_q[$];
  int                mptr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rd_addr     (rd_addr),
    .wb_data     (wb_data),
    .reg_write   (reg_write),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .stall       (stall),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr      = NREQ - 1;
    last_addr = '0;
    last_data = '0;
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // One clock: predict the grant, push the expected write, clock, pop and compare
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int              idx;
    int              gidx;
    bit              found;
    wr_t             e;
    logic [ADDR_W-1:0] a;
    #1;
    exp_rdy = '0;
    found   = 0;
    gidx    = 0;
    idx     = mptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx + 1) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1;
        gidx  = idx;
      end
    end
    if (found) exp_rdy[gidx] = 1'b1;
    chk(32'(req_ready), 32'(exp_rdy), "ready");
    e.we   = 1'b0;
    e.addr = last_addr;
    e.data = last_data;
    if (found) begin
      mptr = gidx;
      a = req_addr[gidx*ADDR_W +: ADDR_W];
      if (a != '0) begin
        e.we      = 1'b1;
        e.addr    = a;
        e.data    = req_data[gidx*DATA_W +: DATA_W];
        last_addr = e.addr;
        last_data = e.data;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk(32'(exp_q.size()), 32'd1, "queue_empty");
    end else begin
      e = exp_q.pop_front();
      chk(32'(reg_write), 32'(e.we), "reg_write");
      chk(32'(rd_addr), 32'(e.addr), "rd_addr");
      chk(32'(wb_data), 32'(e.data), "wb_data");
    end
  endtask

  initial begin
    int order[6] = '{0, 1, 2, 0, 1, 2};

    rst_n       = 1'b0;
    req_valid   = '1;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b1;
    issue_addr  = 3'd5;
    rs1_addr    = 3'd5;
    rs2_addr    = 3'd0;
    set_req(0, 3'd1, 19'h11111);
    set_req(1, 3'd2, 19'h22222);
    set_req(2, 3'd4, 19'h34444);
    model_reset();

    // Reset held 3 cycles with every requester asking
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk(32'(req_ready), 32'd0, "rst_ready");
      chk(32'(reg_write), 32'd0, "rst_reg_write");
      chk(32'(busy), 32'd0, "rst_busy");
      chk(32'(stall), 32'd0, "rst_stall");
      chk(32'(rd_addr), 32'd0, "rst_rd_addr");
      chk(32'(wb_data), 32'd0, "rst_wb_data");
    end
    rst_n       = 1'b1;
    req_valid   = '0;
    issue_valid = 1'b0;
    rs1_addr    = 3'd0;
    step();

    // Single write from the FFT slot
    req_valid = 3'b010;
    set_req(1, 3'd5, 19'h1ABCD);
    #1;
    chk(32'(req_ready), 32'b010, "single_ready");
    step();
    chk(32'(reg_write), 32'd1, "single_we");
    chk(32'(rd_addr), 32'd5, "single_addr");
    chk(32'(wb_data), 32'h1ABCD, "single_data");
    req_valid = '0;
    step();
    chk(32'(rd_addr), 32'd5, "hold_addr");

    // Contention straight after a reset
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n     = 1'b1;
    req_valid = 3'b111;
    set_req(0, 3'd1, 19'h11111);
    set_req(1, 3'd2, 19'h22222);
    set_req(2, 3'd4, 19'h34444);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk(32'(req_ready), 32'(1 << order[i]), "cont_order");
      step();
      chk(32'(reg_write), 32'd1, "cont_we");
    end

    // Register 0 is accepted but never written
    req_valid = 3'b100;
    set_req(2, 3'd0, 19'h7FFFF);
    #1;
    chk(32'(req_ready), 32'b100, "r0_ready");
    step();
    chk(32'(reg_write), 32'd0, "r0_no_write");
    chk(32'(rd_addr), 32'd4, "r0_hold_addr");

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      req_valid = NREQ'($urandom_range(0, 7));
      for (int r = 0; r < NREQ; r++) begin
        set_req(r, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      end
      step();
    end
    req_valid = '0;
    step();

`ifdef WB_SCOREBOARD_EN
    // Scoreboard: issue to 3, stall until the ALU writes 3
    issue_valid = 1'b1;
    issue_addr  = 3'd3;
    step();
    issue_valid = 1'b0;
    rs1_addr    = 3'd3;
    #1;
    chk(32'(stall), 32'd1, "sb_stall_set");
    chk(32'(busy), 32'h08, "sb_busy_set");
    step();
    chk(32'(stall), 32'd1, "sb_stall_hold");
    req_valid = 3'b001;
    set_req(0, 3'd3, 19'h00333);
    #1;
    chk(32'(stall), 32'd1, "sb_stall_write_cycle");
    step();
    req_valid = '0;
    chk(32'(stall), 32'd0, "sb_stall_cleared");
    chk(32'(busy), 32'h00, "sb_busy_cleared");
    // Issue and write of the same register in one cycle
    issue_valid = 1'b1;
    issue_addr  = 3'd3;
    req_valid   = 3'b001;
    step();
    issue_valid = 1'b0;
    req_valid   = '0;
    chk(32'(busy), 32'h08, "sb_set_wins");
    issue_valid = 1'b1;
    issue_addr  = 3'd0;
    step();
    issue_valid = 1'b0;
    chk(32'(busy), 32'h08, "sb_r0_ignored");
    rs1_addr = 3'd0;
    rs2_addr = 3'd3;
    #1;
    chk(32'(stall), 32'd1, "sb_stall_rs2");
    rs2_addr = 3'd0;
`else
    issue_valid = 1'b1;
    issue_addr  = 3'd3;
    rs1_addr    = 3'd3;
    step();
    issue_valid = 1'b0;
    chk(32'(busy), 32'd0, "nosb_busy");
    chk(32'(stall), 32'd0, "nosb_stall");
    rs1_addr = 3'd0;
`endif

    // Reset in the cycle after a grant drops the in-flight write
    req_valid = 3'b010;
    set_req(1, 3'd7, 19'h55555);
    issue_valid = 1'b1;
    issue_addr  = 3'd6;
    #1;
    chk(32'(req_ready != 0), 32'd1, "mid_grant");
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk(32'(reg_write), 32'd0, "mid_no_write");
    chk(32'(busy), 32'd0, "mid_busy");
    chk(32'(req_ready), 32'd0, "mid_ready");
    @(posedge clk);
    #1;
    chk(32'(reg_write), 32'd0, "mid_no_write_hold");
    model_reset();
    rst_n     = 1'b1;
    req_valid = '0;
    step();
    chk(32'(rd_addr), 32'd0, "mid_rd_addr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
